// File: rtl/xilinx_pcie_clk_ctrl_pkg.sv
// Shared types for the PCIe PIPE-clock MMCM sequencer.
// State encoding and counter width helper.
package xilinx_pcie_clk_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RST,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_READY,
    ST_GATE_OFF,
    ST_SWITCH,
    ST_GATE_ON,
    ST_FAIL
  } state_e;

  function automatic int cnt_w(input int v);
    return (v < 1) ? 1 : $clog2(v + 1);
  endfunction

endpackage

// File: rtl/pcie_cdc_sync.sv
// Two-flop synchronizer for quasi-static inputs
// arriving from another clock domain.
module pcie_cdc_sync #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  (* ASYNC_REG = "TRUE" *) logic [W-1:0] s1_q;
  (* ASYNC_REG = "TRUE" *) logic [W-1:0] s2_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/xilinx_pcie_clk_ctrl.sv
// PIPE-clock MMCM sequencer: reset/lock/retry, debounce, Gen1/Gen2 switch.
// Optional PCIE_CLK_CTRL_STATS_EN adds lock-loss and retry counters.
module xilinx_pcie_clk_ctrl
  import xilinx_pcie_clk_ctrl_pkg::*;
#(
  parameter int PCIE_LANE    = 1,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int LOCK_STABLE  = 64,
  parameter int GATE_CYCLES  = 8,
  parameter int MAX_RETRY    = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 mmcm_lock_i,
  input  logic [PCIE_LANE-1:0] pclk_sel_i,
  output logic                 mmcm_rst_n_o,
  output logic                 pipeclk_en_o,
  output logic [PCIE_LANE-1:0] pclk_sel_o,
  output logic                 clk_ready_o,
  output logic                 rate_done_o,
  output logic                 fail_o
`ifdef PCIE_CLK_CTRL_STATS_EN
  ,
  output logic [7:0]           lock_loss_cnt_o,
  output logic [7:0]           retry_total_o
`endif
);

  localparam int RW = cnt_w(RST_CYCLES);
  localparam int TW = cnt_w(LOCK_TIMEOUT);
  localparam int SW = cnt_w(LOCK_STABLE);
  localparam int GW = cnt_w(GATE_CYCLES);
  localparam int YW = cnt_w(MAX_RETRY);

  localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TOUT      = TW'(LOCK_TIMEOUT);
  localparam logic [SW-1:0] STAB      = SW'(LOCK_STABLE);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [YW-1:0] RETRY_MAX = YW'(MAX_RETRY);

  logic                 lock_s;
  logic [PCIE_LANE-1:0] sel_s;

  pcie_cdc_sync #(.W(1)) u_lock_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (mmcm_lock_i),
    .q_o     (lock_s)
  );

  pcie_cdc_sync #(.W(PCIE_LANE)) u_sel_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (pclk_sel_i),
    .q_o     (sel_s)
  );

  state_e               state_q, state_d;
  logic [RW-1:0]        rcnt_q, rcnt_d;
  logic [TW-1:0]        tcnt_q, tcnt_d, tcnt_inc;
  logic [SW-1:0]        scnt_q, scnt_d, scnt_inc;
  logic [GW-1:0]        gcnt_q, gcnt_d;
  logic [YW-1:0]        retry_q, retry_d, retry_inc;
  logic [PCIE_LANE-1:0] sel_q, sel_d;
  logic                 done_q, done_d;
  logic                 req;

  // Only a unanimous lane request that differs from the applied rate counts
  assign req = (&sel_s && ~|sel_q) || (~|sel_s && |sel_q);

  assign tcnt_inc  = (tcnt_q == TOUT) ? tcnt_q : tcnt_q + 1'b1;
  assign scnt_inc  = scnt_q + 1'b1;
  assign retry_inc = retry_q + 1'b1;

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    tcnt_d  = tcnt_q;
    scnt_d  = scnt_q;
    gcnt_d  = gcnt_q;
    retry_d = retry_q;
    sel_d   = sel_q;
    unique case (state_q)
      ST_RST: begin
        sel_d = '0;
        if (rcnt_q == RST_LAST) begin
          rcnt_d  = '0;
          tcnt_d  = '0;
          state_d = ST_WAIT_LOCK;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        tcnt_d = tcnt_inc;
        if (lock_s) begin
          scnt_d  = '0;
          state_d = ST_STABLE;
        end else if (tcnt_inc == TOUT) begin
          retry_d = retry_inc;
          rcnt_d  = '0;
          state_d = (retry_inc == RETRY_MAX) ? ST_FAIL : ST_RST;
        end
      end
      ST_STABLE: begin
        tcnt_d = tcnt_inc;
        if (!lock_s) begin
          scnt_d  = '0;
          state_d = ST_WAIT_LOCK;
        end else begin
          scnt_d = scnt_inc;
          if (scnt_inc == STAB) begin
            retry_d = '0;
            state_d = ST_READY;
          end
        end
      end
      ST_READY: begin
        if (!lock_s) begin
          rcnt_d  = '0;
          sel_d   = '0;
          state_d = ST_RST;
        end else if (req) begin
          gcnt_d  = '0;
          state_d = ST_GATE_OFF;
        end
      end
      ST_GATE_OFF, ST_SWITCH, ST_GATE_ON: begin
        if (!lock_s) begin
          rcnt_d  = '0;
          sel_d   = '0;
          state_d = ST_RST;
        end else if (state_q == ST_SWITCH) begin
          gcnt_d  = '0;
          state_d = ST_GATE_ON;
        end else if (gcnt_q == GATE_LAST) begin
          gcnt_d = '0;
          if (state_q == ST_GATE_OFF) begin
            sel_d   = ~sel_q;
            state_d = ST_SWITCH;
          end else begin
            state_d = ST_READY;
          end
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      ST_FAIL: state_d = ST_FAIL;
      default: state_d = ST_RST;
    endcase
    done_d = (state_q == ST_GATE_ON) && (state_d == ST_READY);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_RST;
      rcnt_q  <= '0;
      tcnt_q  <= '0;
      scnt_q  <= '0;
      gcnt_q  <= '0;
      retry_q <= '0;
      sel_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      tcnt_q  <= tcnt_d;
      scnt_q  <= scnt_d;
      gcnt_q  <= gcnt_d;
      retry_q <= retry_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
    end
  end

  assign mmcm_rst_n_o = (state_q != ST_RST) && (state_q != ST_FAIL);
  assign pipeclk_en_o = (state_q == ST_READY);
  assign clk_ready_o  = (state_q == ST_READY)    ||
                        (state_q == ST_GATE_OFF) ||
                        (state_q == ST_SWITCH)   ||
                        (state_q == ST_GATE_ON);
  assign fail_o       = (state_q == ST_FAIL);
  assign rate_done_o  = done_q;
  assign pclk_sel_o   = sel_q;

`ifdef PCIE_CLK_CTRL_STATS_EN
  logic [7:0] loss_q, loss_d;
  logic [7:0] rtot_q, rtot_d;
  logic       loss_ev, tout_ev;

  always_comb begin
    loss_ev = clk_ready_o && !lock_s;
    tout_ev = (state_q == ST_WAIT_LOCK) &&
              ((state_d == ST_RST) || (state_d == ST_FAIL));
    loss_d  = loss_q;
    rtot_d  = rtot_q;
    if (loss_ev && (loss_q != 8'hff)) loss_d = loss_q + 8'd1;
    if (tout_ev && (rtot_q != 8'hff)) rtot_d = rtot_q + 8'd1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      loss_q <= '0;
      rtot_q <= '0;
    end else begin
      loss_q <= loss_d;
      rtot_q <= rtot_d;
    end
  end

  assign lock_loss_cnt_o = loss_q;
  assign retry_total_o   = rtot_q;
`endif

endmodule

// File: tb/tb_xilinx_pcie_clk_ctrl.sv
// Randomized self-checking bench for xilinx_pcie_clk_ctrl.
// Expected timing is derived arithmetically from the parameters.
module tb_xilinx_pcie_clk_ctrl;

  localparam int LN = 2;
  localparam int RC = 4;
  localparam int LT = 100;
  localparam int LS = 8;
  localparam int GC = 4;
  localparam int MR = 3;
  // 2 synchronizer flops + 1 cycle for the FSM to react
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          lock = 1'b0;
  logic [LN-1:0] sel_i = '0;
  logic          mmcm_rst_n, en, ready, done, fail;
  logic [LN-1:0] sel_o;
`ifdef PCIE_CLK_CTRL_STATS_EN
  logic [7:0]    loss_cnt, retry_tot;
`endif

  xilinx_pcie_clk_ctrl #(
    .PCIE_LANE    (LN),
    .RST_CYCLES   (RC),
    .LOCK_TIMEOUT (LT),
    .LOCK_STABLE  (LS),
    .GATE_CYCLES  (GC),
    .MAX_RETRY    (MR)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .mmcm_lock_i  (lock),
    .pclk_sel_i   (sel_i),
    .mmcm_rst_n_o (mmcm_rst_n),
    .pipeclk_en_o (en),
    .pclk_sel_o   (sel_o),
    .clk_ready_o  (ready),
    .rate_done_o  (done),
    .fail_o       (fail)
`ifdef PCIE_CLK_CTRL_STATS_EN
    ,
    .lock_loss_cnt_o (loss_cnt),
    .retry_total_o   (retry_tot)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [LN-1:0] exp_sel = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return {25'd0, mmcm_rst_n, en, sel_o, ready, done, fail};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    lock = 1'b0;
    sel_i = '0;
    exp_sel = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic lock_up(input int d, output int lowlen);
    lowlen = 0;
    while (!mmcm_rst_n && lowlen < 50) begin
      lowlen++;
      tick();
    end
    repeat (d) tick();
    lock = 1'b1;
  endtask

  task automatic wait_ready(output int n, output int early);
    n = 0;
    early = 0;
    while (!ready && n < 400) begin
      if (en || done) early++;
      tick();
      n++;
    end
  endtask

  task automatic do_switch(input logic [LN-1:0] tgt);
    int n, bad;
    bad = 0;
    sel_i = tgt;
    n = 0;
    while (en && n < 50) begin
      tick();
      n++;
    end
    chk("sw_fall", n, LAT);
    n = 0;
    while (!en && sel_o === exp_sel && n < 50) begin
      if (!ready || done) bad++;
      tick();
      n++;
    end
    chk("sw_gate_off", n, GC);
    exp_sel = tgt;
    n = 0;
    while (!en && sel_o === exp_sel && n < 50) begin
      if (!ready || done) bad++;
      tick();
      n++;
    end
    chk("sw_gate_on", n, GC + 1);
    chk("sw_sel", sel_o, exp_sel);
    chk("sw_en", en, 1);
    chk("sw_done", done, 1);
    tick();
    chk("sw_done_pulse", done, 0);
    chk("sw_gate_bad", bad, 0);
  endtask

  task automatic hold_check(input string tag, input int cyc);
    int bad;
    bad = 0;
    repeat (cyc) begin
      tick();
      if (outs() !== {25'd0, 1'b1, 1'b1, exp_sel, 1'b1, 1'b0, 1'b0})
        bad++;
    end
    chk(tag, bad, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, early, d, g, bad;
    logic [LN-1:0] mix, tgt;

    tick();
    chk("reset_outs", outs(), 0);
`ifdef PCIE_CLK_CTRL_STATS_EN
    chk("reset_stats", {loss_cnt, retry_tot}, 0);
`endif

    // Session A: power-up, mixed requests, switches, loss mid-switch
    do_reset();
    d = $urandom_range(20, 5);
    lock_up(d, n);
    chk("pu_rst_len", n, RC);
    wait_ready(n, early);
    chk("pu_ready_lat", n, LAT + LS);
    chk("pu_early", early, 0);
    chk("pu_en", en, 1);
    chk("pu_mmcm", mmcm_rst_n, 1);
    chk("pu_sel", sel_o, 0);

    for (int i = 0; i < 4; i++) begin
      mix = ($urandom_range(1, 0) == 0) ? 2'b01 : 2'b10;
      sel_i = mix;
      hold_check("mixed_hold", 50);
      sel_i = exp_sel;
      hold_check("idle_hold", $urandom_range(20, 3));
      tgt = (exp_sel == '0) ? '1 : '0;
      do_switch(tgt);
    end

    tgt = (exp_sel == '0) ? '1 : '0;
    sel_i = tgt;
    n = 0;
    while (en && n < 50) begin
      tick();
      n++;
    end
    chk("ll_fall", n, LAT);
    repeat (GC + 1) tick();
    lock = 1'b0;
    bad = 0;
    repeat (3) begin
      tick();
      if (done) bad++;
    end
    chk("ll_ready", ready, 0);
    chk("ll_sel", sel_o, 0);
    chk("ll_en", en, 0);
    chk("ll_mmcm", mmcm_rst_n, 0);
    repeat (10) begin
      tick();
      if (done) bad++;
    end
    chk("ll_no_done", bad, 0);
`ifdef PCIE_CLK_CTRL_STATS_EN
    chk("ll_loss_cnt", loss_cnt, 1);
    chk("ll_retry_tot", retry_tot, 0);
`endif

    // Session B: lock glitch during the stability window
    do_reset();
    d = $urandom_range(20, 0);
    lock_up(d, n);
    chk("gl_rst_len", n, RC);
    g = $urandom_range(LS - 3, 1);
    bad = 0;
    repeat (LAT + g) begin
      tick();
      if (ready) bad++;
    end
    lock = 1'b0;
    tick();
    if (ready) bad++;
    lock = 1'b1;
    wait_ready(n, early);
    chk("gl_ready_lat", n, LAT + LS);
    chk("gl_early", bad + early, 0);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outs", outs(), 0);
    tick();
    rst_n = 1'b1;

    // Session C: lock never arrives
    do_reset();
    bad = 0;
    for (int k = 0; k < MR; k++) begin
      n = 0;
      while (!mmcm_rst_n && n < 300) begin
        if (fail) bad++;
        n++;
        tick();
      end
      chk("to_low_len", n, RC);
      n = 0;
      while (mmcm_rst_n && n < 300) begin
        if (fail) bad++;
        n++;
        tick();
      end
      chk("to_wait_len", n, LT);
    end
    chk("to_early_fail", bad, 0);
    chk("to_fail", fail, 1);
    repeat (50) tick();
    chk("to_fail_hold", {fail, mmcm_rst_n, en, ready}, 4'b1000);
`ifdef PCIE_CLK_CTRL_STATS_EN
    chk("to_retry_tot", retry_tot, MR);
    chk("to_loss_cnt", loss_cnt, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
